// File: rtl/stream_packetizer.sv
// Frames a FIFO word stream into {seq, len} header + payload packets behind one output register.
// Define PKT_CHECKSUM_EN to append an XOR trailer word (header ^ payload) carrying o_last_m.
module stream_packetizer #(
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 8,
    parameter int SEQ_WIDTH  = DATA_WIDTH - LEN_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid_s,
    input  logic [DATA_WIDTH-1:0] i_data_s,
    output logic                  o_ready_s,
    input  logic [LEN_WIDTH-1:0]  i_pkt_len,
    output logic                  o_valid_m,
    output logic [DATA_WIDTH-1:0] o_data_m,
    output logic                  o_sop_m,
    output logic                  o_last_m,
    input  logic                  i_ready_m,
    output logic                  o_busy
);

    localparam int HDR_W = SEQ_WIDTH + LEN_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_CSUM} state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_sop;
    logic                  r_last;
    logic [LEN_WIDTH-1:0]  r_cnt;
    logic [SEQ_WIDTH-1:0]  r_seq;

    logic                  w_free;
    logic                  w_ready_s;
    logic                  w_load_hdr;
    logic                  w_pop;
    logic                  w_cnt_one;
    logic [LEN_WIDTH-1:0]  w_len_eff;
    logic [HDR_W-1:0]      w_hdr_raw;
    logic [DATA_WIDTH-1:0] w_hdr;

    assign w_free    = !r_valid || i_ready_m;
    assign w_len_eff = (i_pkt_len == '0) ? LEN_WIDTH'(1) : i_pkt_len;
    assign w_hdr_raw = {r_seq, w_len_eff};
    assign w_hdr     = DATA_WIDTH'(w_hdr_raw);
    assign w_pop     = i_valid_s && w_ready_s;
    assign w_cnt_one = (r_cnt == LEN_WIDTH'(1));

`ifdef PKT_CHECKSUM_EN
    logic                  w_load_csum;
    logic [DATA_WIDTH-1:0] r_csum;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (i_valid_s && w_free) w_next = S_PAYLOAD;
            S_PAYLOAD: begin
                if (w_pop && w_cnt_one) begin
`ifdef PKT_CHECKSUM_EN
                    w_next = S_CSUM;
`else
                    w_next = S_IDLE;
`endif
                end
            end
`ifdef PKT_CHECKSUM_EN
            S_CSUM:    if (w_free) w_next = S_IDLE;
`endif
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_ready_s  = 1'b0;
        w_load_hdr = 1'b0;
`ifdef PKT_CHECKSUM_EN
        w_load_csum = 1'b0;
`endif
        case (r_state)
            S_IDLE:    w_load_hdr = i_valid_s && w_free;
            S_PAYLOAD: w_ready_s  = w_free;
`ifdef PKT_CHECKSUM_EN
            S_CSUM:    w_load_csum = w_free;
`endif
            default:   ;
        endcase
    end

    // Output stage: a loaded word holds until the downstream accepts it
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sop   <= 1'b0;
            r_last  <= 1'b0;
            r_cnt   <= '0;
            r_seq   <= '0;
        end else if (w_load_hdr) begin
            r_valid <= 1'b1;
            r_data  <= w_hdr;
            r_sop   <= 1'b1;
            r_last  <= 1'b0;
            r_cnt   <= w_len_eff;
            r_seq   <= r_seq + SEQ_WIDTH'(1);
        end else if (w_pop) begin
            r_valid <= 1'b1;
            r_data  <= i_data_s;
            r_sop   <= 1'b0;
`ifdef PKT_CHECKSUM_EN
            r_last  <= 1'b0;
`else
            r_last  <= w_cnt_one;
`endif
            r_cnt   <= r_cnt - LEN_WIDTH'(1);
`ifdef PKT_CHECKSUM_EN
        end else if (w_load_csum) begin
            r_valid <= 1'b1;
            r_data  <= r_csum;
            r_sop   <= 1'b0;
            r_last  <= 1'b1;
`endif
        end else if (w_free) begin
            r_valid <= 1'b0;
        end
    end

`ifdef PKT_CHECKSUM_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)           r_csum <= '0;
        else if (w_load_hdr) r_csum <= w_hdr;
        else if (w_pop)      r_csum <= r_csum ^ i_data_s;
    end
`endif

    assign o_ready_s = w_ready_s;
    assign o_valid_m = r_valid;
    assign o_data_m  = r_data;
    assign o_sop_m   = r_sop;
    assign o_last_m  = r_last;
    assign o_busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_stream_packetizer.sv
// Directed bench for stream_packetizer: FIFO model on the input, word log on the output.
module tb_stream_packetizer;

`ifdef PKT_CHECKSUM_EN
    localparam int WPP1 = 3;
    localparam int B2B  = 12;
`else
    localparam int WPP1 = 2;
    localparam int B2B  = 9;
`endif

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_valid_s;
    logic [15:0] i_data_s;
    logic        o_ready_s;
    logic [7:0]  i_pkt_len;
    logic        o_valid_m;
    logic [15:0] o_data_m;
    logic        o_sop_m;
    logic        o_last_m;
    logic        i_ready_m;
    logic        o_busy;

    int checks = 0;
    int failures = 0;

    stream_packetizer #(.DATA_WIDTH(16), .LEN_WIDTH(8)) dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_valid_s(i_valid_s), .i_data_s(i_data_s), .o_ready_s(o_ready_s),
        .i_pkt_len(i_pkt_len),
        .o_valid_m(o_valid_m), .o_data_m(o_data_m), .o_sop_m(o_sop_m), .o_last_m(o_last_m),
        .i_ready_m(i_ready_m), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    // Input FIFO model
    logic [15:0] mem [0:1023];
    int wr = 0;
    int rd = 0;
    assign i_valid_s = (rd != wr);
    assign i_data_s  = mem[rd[9:0]];
    always @(posedge clk) if (i_valid_s && o_ready_s) rd <= rd + 1;

    // Output log: {sop, last, data} and the cycle each word transferred
    logic [17:0] logw [$];
    int          logc [$];
    int          cyc = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (o_valid_m && i_ready_m) begin
            logw.push_back({o_sop_m, o_last_m, o_data_m});
            logc.push_back(cyc);
        end
    end

    logic [17:0] expq [$];
    logic [15:0] xacc;
    int          base;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] d);
        mem[wr] = d;
        wr++;
    endtask

    task automatic begin_test();
        base = logw.size();
        expq.delete();
    endtask

    task automatic e_hdr(input logic [7:0] seq, input logic [7:0] len);
        expq.push_back({2'b10, seq, len});
        xacc = {seq, len};
    endtask

    task automatic e_pay(input logic [15:0] d, input logic last);
        xacc = xacc ^ d;
`ifdef PKT_CHECKSUM_EN
        expq.push_back({2'b00, d});
        if (last) expq.push_back({2'b01, xacc});
`else
        expq.push_back({1'b0, last, d});
`endif
    endtask

    task automatic wait_words(input string tag, input int n, input int budget);
        int k = 0;
        while (logw.size() < base + n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_timeout"}, 64'(logw.size() >= base + n), 64'd1);
    endtask

    task automatic compare(input string tag);
        logic [17:0] obs;
        wait_words(tag, expq.size(), 300);
        for (int i = 0; i < expq.size(); i++) begin
            obs = (base + i < logw.size()) ? logw[base + i] : 18'h3FFFF;
            check($sformatf("%s_w%0d", tag, i), 64'(obs), 64'(expq[i]));
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, 64'(o_valid_m), 64'd0);
        check({tag, "_data"},  64'(o_data_m),  64'd0);
        check({tag, "_sop"},   64'(o_sop_m),   64'd0);
        check({tag, "_last"},  64'(o_last_m),  64'd0);
        check({tag, "_ready"}, 64'(o_ready_s), 64'd0);
        check({tag, "_busy"},  64'(o_busy),    64'd0);
    endtask

    initial begin
        int lasts;
        i_rst = 1'b1;
        i_ready_m = 1'b1;
        i_pkt_len = 8'd3;
        #3;
        check_zero_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        i_rst = 1'b0;
        @(negedge clk);
        check("idle_valid", 64'(o_valid_m), 64'd0);
        check("idle_busy",  64'(o_busy),    64'd0);

        // Single packet with per-cycle latency checks
        begin_test();
        e_hdr(8'd0, 8'd3); e_pay(16'h000A, 0); e_pay(16'h000B, 0); e_pay(16'h000C, 1);
        push(16'h000A); push(16'h000B); push(16'h000C);
        @(negedge clk);
        check("single_hdr_valid", 64'(o_valid_m), 64'd1);
        check("single_hdr_sop",   64'(o_sop_m),   64'd1);
        check("single_hdr_data",  64'(o_data_m),  64'h0003);
        check("single_busy",      64'(o_busy),    64'd1);
        @(negedge clk);
        check("single_p1", 64'(o_data_m), 64'h000A);
        @(negedge clk);
        check("single_p2", 64'(o_data_m), 64'h000B);
        @(negedge clk);
        check("single_p3", 64'(o_data_m), 64'h000C);
`ifndef PKT_CHECKSUM_EN
        check("single_p3_last", 64'(o_last_m), 64'd1);
`endif
        compare("single");

        // Backpressure in the middle of the payload
        begin_test();
        e_hdr(8'd1, 8'd3); e_pay(16'h0011, 0); e_pay(16'h0022, 0); e_pay(16'h0033, 1);
        push(16'h0011); push(16'h0022); push(16'h0033);
        @(negedge clk);
        @(negedge clk);
        check("bp_p1", 64'(o_data_m), 64'h0011);
        i_ready_m = 1'b0;
        #1;
        check("bp_ready_s0", 64'(o_ready_s), 64'd0);
        @(negedge clk);
        check("bp_hold1_data",  64'(o_data_m),  64'h0011);
        check("bp_hold1_valid", 64'(o_valid_m), 64'd1);
        check("bp_hold1_ready", 64'(o_ready_s), 64'd0);
        @(negedge clk);
        check("bp_hold2_data",  64'(o_data_m),  64'h0011);
        i_ready_m = 1'b1;
        compare("bp");

        // FIFO underflow mid-packet; length change during packet is ignored
        begin_test();
        e_hdr(8'd2, 8'd4);
        e_pay(16'h0041, 0); e_pay(16'h0042, 0); e_pay(16'h0043, 0); e_pay(16'h0044, 1);
        i_pkt_len = 8'd4;
        push(16'h0041); push(16'h0042);
        @(negedge clk);
        i_pkt_len = 8'd7;
        repeat (10) @(negedge clk);
        check("uf_busy",  64'(o_busy), 64'd1);
        check("uf_count", 64'(logw.size() - base), 64'd3);
        lasts = 0;
        for (int i = base; i < logw.size(); i++) lasts += int'(logw[i][16]);
        check("uf_no_early_last", 64'(lasts), 64'd0);
        push(16'h0043); push(16'h0044);
        compare("uf");

        // Zero length behaves as one
        begin_test();
        i_pkt_len = 8'd0;
        e_hdr(8'd3, 8'd1); e_pay(16'h0055, 1);
        push(16'h0055);
        compare("zero");

        // Back-to-back packets with no idle cycle
        begin_test();
        i_pkt_len = 8'd2;
        for (int p = 0; p < 3; p++) begin
            e_hdr(8'(4 + p), 8'd2);
            e_pay(16'(16'h0061 + 2 * p), 0);
            e_pay(16'(16'h0062 + 2 * p), 1);
        end
        for (int i = 0; i < 6; i++) push(16'(16'h0061 + i));
        compare("b2b");
        check("b2b_cycles", 64'(logc[base + B2B - 1] - logc[base] + 1), 64'(B2B));

        // Reset after header and one payload word
        i_pkt_len = 8'd3;
        push(16'h0071); push(16'h0072); push(16'h0073);
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_p1", 64'(o_data_m), 64'h0071);
        #1 i_rst = 1'b1;
        #1;
        check_zero_outputs("rst_mid");
        @(negedge clk);
        begin_test();
        i_pkt_len = 8'd2;
        i_rst = 1'b0;
        e_hdr(8'd0, 8'd2); e_pay(16'h0072, 0); e_pay(16'h0073, 1);
        compare("rst_after");

        // Sequence wrap over 257 single-word packets
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        i_pkt_len = 8'd1;
        begin_test();
        for (int i = 0; i < 257; i++) push(16'(16'h0100 + i));
        wait_words("wrap", 257 * WPP1, 2000);
        check("wrap_hdr255", 64'((base + 255 * WPP1 < logw.size()) ? logw[base + 255 * WPP1] : 18'h3FFFF),
              64'({2'b10, 16'hFF01}));
        check("wrap_hdr256", 64'((base + 256 * WPP1 < logw.size()) ? logw[base + 256 * WPP1] : 18'h3FFFF),
              64'({2'b10, 16'h0001}));
        check("wrap_pay256", 64'((base + 256 * WPP1 + 1 < logw.size()) ? logw[base + 256 * WPP1 + 1][15:0] : 16'hFFFF),
              64'h0200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
